// File: rtl/rv32_pkg.sv
// Shared RV32 definitions used by the fetch unit and the decoder.
package rv32_pkg;

  localparam int              XLEN             = 32;
  localparam int              INST_BYTES       = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic {
    BOOT,
    RUN
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch stage.
interface if_fetch_unit_if;
  import rv32_pkg::*;

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            inst_valid;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect_valid, redirect_pc, inst_ready
  );

endinterface

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Small synchronous FIFO with flush; used for the instruction buffer and the PC queue.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited word fetches and buffers returned
// instructions for decode; a redirect flushes the path and drops in-flight responses.
module if_fetch_unit
  import rv32_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int              BUF_DEPTH = 2
) (
  input logic            clk,
  input logic            rst_n,
  if_fetch_unit_if.master bus
);

  localparam int CW  = $clog2(BUF_DEPTH + 1);
  localparam int CW1 = CW + 1;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic            running, redirect_run, pop, accept, resp, resp_keep;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   inst_count, pcq_count;
  logic            inst_full, inst_empty, pcq_full, pcq_empty;
  logic [XLEN-1:0] pcq_head;
  logic [2*XLEN-1:0] inst_head;
  logic            unused_sink;

  always_comb begin
    state_d       = RUN;  // BOOT only ever lasts the single cycle after reset
    fetch_pc_d    = fetch_pc_q;
    drop_d        = drop_q;
    running       = (state_q == RUN);
    redirect_run  = running && bus.redirect_valid;

    bus.inst_valid = !inst_empty && !bus.redirect_valid;
    pop            = bus.inst_valid && bus.inst_ready;

    // Credits count live + stale requests in flight plus buffered words, net of this cycle's pop.
    credit_used        = {1'b0, outstanding_q} + {1'b0, inst_count} - {{CW{1'b0}}, pop};
    bus.imem_req_valid = running && (credit_used < CW1'(BUF_DEPTH)) && !bus.redirect_valid;
    bus.imem_req_addr  = fetch_pc_q;
    accept             = bus.imem_req_valid && bus.imem_req_ready;

    resp          = running && bus.imem_resp_valid && (outstanding_q != '0);
    resp_keep     = resp && (drop_q == '0) && !redirect_run;
    outstanding_d = outstanding_q + CW'(accept) - CW'(resp);

    if (accept) fetch_pc_d = fetch_pc_q + XLEN'(INST_BYTES);

    if (redirect_run) begin
      fetch_pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
      drop_d     = outstanding_q + CW'(accept) - CW'(resp);
    end else if (resp && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  fetch_fifo #(.WIDTH(XLEN), .DEPTH(BUF_DEPTH)) u_pc_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (resp_keep),
    .flush (redirect_run),
    .wdata (fetch_pc_q),
    .rdata (pcq_head),
    .count (pcq_count),
    .full  (pcq_full),
    .empty (pcq_empty)
  );

  fetch_fifo #(.WIDTH(2 * XLEN), .DEPTH(BUF_DEPTH)) u_inst_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp_keep),
    .pop   (pop),
    .flush (redirect_run),
    .wdata ({bus.imem_resp_data, pcq_head}),
    .rdata (inst_head),
    .count (inst_count),
    .full  (inst_full),
    .empty (inst_empty)
  );

  assign bus.inst    = inst_head[2*XLEN-1:XLEN];
  assign bus.inst_pc = inst_head[XLEN-1:0];

  assign unused_sink = ^{pcq_count, pcq_full, pcq_empty, inst_full, bus.redirect_pc[1:0]};

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench: randomized memory/decode timing against an in-order fetch-stream model.
module tb_if_fetch_unit;

  localparam int          DEPTH   = 2;
  localparam logic [31:0] PC_A    = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  if_fetch_unit_if bus_a ();
  if_fetch_unit_if bus_b ();

  if_fetch_unit #(.RESET_PC(PC_A), .BUF_DEPTH(DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  if_fetch_unit #(.RESET_PC(WRAP_PC), .BUF_DEPTH(DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    memq[$];
  int          checks = 0, failures = 0, cyc = 0, lat = 1, pops = 0;
  int unsigned req_ready_pct = 100, inst_ready_pct = 100;
  logic [31:0] exp_pc, exp_req;
  int          last_pop_cyc = -1;
  logic [31:0] last_pop_pc, last_pop_inst, last_req_addr, prev_addr;
  logic        last_req_valid, last_inst_valid, prev_stall;
  logic        rst_h1 = 1'b1, rst_h2 = 1'b1;
  logic        b_resp_pend;
  logic [31:0] b_resp_addr;
  logic [31:0] b_pcs[$];

  // Memory contents: address 0 holds 0x00A00093, everything else a scrambled word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00A0_0093;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    bus_a.imem_req_ready = ($urandom_range(99) < req_ready_pct);
    bus_a.inst_ready     = ($urandom_range(99) < inst_ready_pct);
    if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
      bus_a.imem_resp_valid = 1'b1;
      bus_a.imem_resp_data  = mem_word(memq[0].addr);
    end else begin
      bus_a.imem_resp_valid = 1'b0;
      bus_a.imem_resp_data  = $urandom;
    end
    bus_b.imem_req_ready  = 1'b1;
    bus_b.inst_ready      = 1'b1;
    bus_b.redirect_valid  = 1'b0;
    bus_b.redirect_pc     = '0;
    bus_b.imem_resp_valid = rst_n && b_resp_pend;
    bus_b.imem_resp_data  = mem_word(b_resp_addr);
  endtask

  task automatic observe();
    logic rv, rr, iv, ir, rd;
    rv = bus_a.imem_req_valid;
    rr = bus_a.imem_req_ready;
    iv = bus_a.inst_valid;
    ir = bus_a.inst_ready;
    rd = bus_a.redirect_valid;
    last_req_valid  = rv;
    last_req_addr   = bus_a.imem_req_addr;
    last_inst_valid = iv;
    if (!rst_n) begin
      if (!rst_h1) begin
        check("in_reset_req_valid", 32'(rv), 0);
        check("in_reset_inst_valid", 32'(iv), 0);
      end
      memq.delete();
      exp_pc      = PC_A;
      exp_req     = PC_A;
      prev_stall  = 1'b0;
      b_resp_pend = 1'b0;
      b_pcs.delete();
    end else begin
      if (!rst_h1) begin
        check("boot_req_valid", 32'(rv), 0);
        check("boot_inst_valid", 32'(iv), 0);
      end else if (!rst_h2 && !rd) begin
        check("first_req_valid", 32'(rv), 1);
        check("first_req_addr", bus_a.imem_req_addr, PC_A);
      end
      if (prev_stall && rv && !rd) check("req_addr_stable", bus_a.imem_req_addr, prev_addr);
      prev_stall = rv && !rr && !rd;
      prev_addr  = bus_a.imem_req_addr;

      if (bus_a.imem_resp_valid) void'(memq.pop_front());
      if (rv && rr) memq.push_back('{bus_a.imem_req_addr, cyc + lat});

      if (rd) begin
        check("redirect_inst_valid", 32'(iv), 0);
        check("redirect_req_valid", 32'(rv), 0);
        exp_pc  = {bus_a.redirect_pc[31:2], 2'b00};
        exp_req = exp_pc;
      end else begin
        if (rv && rr) begin
          check("req_addr", bus_a.imem_req_addr, exp_req);
          exp_req += 32'd4;
        end
        if (iv && ir) begin
          check("inst_pc", bus_a.inst_pc, exp_pc);
          check("inst_word", bus_a.inst, mem_word(exp_pc));
          last_pop_pc   = bus_a.inst_pc;
          last_pop_inst = bus_a.inst;
          last_pop_cyc  = cyc;
          exp_pc += 32'd4;
          pops++;
        end
        check("credit_bound", 32'((exp_req - exp_pc) <= 32'(4 * DEPTH)), 1);
      end

      if (bus_b.imem_resp_valid) b_resp_pend = 1'b0;
      if (bus_b.imem_req_valid && bus_b.imem_req_ready) begin
        b_resp_pend = 1'b1;
        b_resp_addr = bus_b.imem_req_addr;
      end
      if (bus_b.inst_valid && bus_b.inst_ready && b_pcs.size() < 3) begin
        b_pcs.push_back(bus_b.inst_pc);
        check("wrap_word", bus_b.inst, mem_word(bus_b.inst_pc));
      end
    end
    rst_h2 = rst_h1;
    rst_h1 = rst_n;
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_pops(input string tag, input int n, input int budget);
    int start, k;
    start = pops;
    k     = 0;
    while (pops - start < n && k < budget) begin
      cycle();
      k++;
    end
    check(tag, 32'(pops - start), 32'(n));
  endtask

  task automatic wait_pop(input int budget);
    int p0, k;
    p0 = pops;
    k  = 0;
    while (pops == p0 && k < budget) begin
      cycle();
      k++;
    end
  endtask

  initial begin
    int c0, p0, k;
    rst_n                = 1'b0;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc    = '0;
    b_resp_pend          = 1'b0;
    b_resp_addr          = '0;
    drive_inputs();
    @(posedge clk);
    #1;
    repeat (3) cycle();

    // Reset release, 1-cycle memory, always-ready decode
    rst_n = 1'b1;
    c0    = cyc;
    cycle();
    wait_pop(10);
    check("first_inst_latency", 32'(last_pop_cyc - c0), 3);
    check("first_inst_pc", last_pop_pc, 32'h0);
    check("first_inst_word", last_pop_inst, 32'h00A0_0093);
    p0 = pops;
    repeat (10) cycle();
    check("throughput", 32'(pops - p0), 10);

    // Decode backpressure
    inst_ready_pct = 0;
    repeat (5) cycle();
    check("bp_req_valid", 32'(last_req_valid), 0);
    check("bp_held", (exp_req - exp_pc) >> 2, DEPTH);
    inst_ready_pct = 100;
    run_pops("bp_resume", 6, 30);

    // Wrap-around instance
    check("wrap_count", 32'(b_pcs.size()), 3);
    for (int i = 0; i < b_pcs.size(); i++)
      check("wrap_pc", b_pcs[i], WRAP_PC + 32'(4 * i));

    // Reset with a full buffer, then memory stall on the second fetch
    inst_ready_pct = 0;
    repeat (4) cycle();
    check("full_before_reset", 32'(last_inst_valid), 1);
    rst_n = 1'b0;
    cycle();
    rst_n          = 1'b1;
    inst_ready_pct = 100;
    cycle();
    check("rst_inst_valid", 32'(last_inst_valid), 0);
    check("rst_req_valid", 32'(last_req_valid), 0);
    cycle();
    req_ready_pct = 0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_req_valid", 32'(last_req_valid), 1);
      check("stall_req_addr", last_req_addr, 32'h4);
    end
    req_ready_pct = 100;
    run_pops("stall_resume", 8, 40);

    // Redirect with two requests in flight, 3-cycle memory
    lat = 3;
    k   = 0;
    while (memq.size() < 2 && k < 20) begin
      cycle();
      k++;
    end
    check("two_in_flight", 32'(memq.size()), 2);
    bus_a.redirect_pc    = 32'h100;
    bus_a.redirect_valid = 1'b1;
    cycle();
    bus_a.redirect_valid = 1'b0;
    wait_pop(30);
    check("redir_first_pc", last_pop_pc, 32'h100);

    // Redirect coincident with a response, unaligned target
    lat = 1;
    run_pops("settle", 4, 40);
    k = 0;
    while (k < 20) begin
      if (memq.size() > 0) begin
        if (memq[0].due <= cyc) break;
      end
      cycle();
      k++;
    end
    bus_a.redirect_pc    = 32'h203;
    bus_a.redirect_valid = 1'b1;
    cycle();
    bus_a.redirect_valid = 1'b0;
    cycle();
    check("redir_next_req_valid", 32'(last_req_valid), 1);
    check("redir_next_req_addr", last_req_addr, 32'h200);
    wait_pop(20);
    check("redir_aligned_pc", last_pop_pc, 32'h200);

    // Randomized traffic with random redirects and latencies
    req_ready_pct  = 70;
    inst_ready_pct = 70;
    for (int blk = 0; blk < 4; blk++) begin
      lat = int'($urandom_range(3, 1));
      for (int i = 0; i < 200; i++) begin
        bus_a.redirect_valid = ($urandom_range(99) < 5);
        bus_a.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                        : $urandom;
        cycle();
      end
    end
    bus_a.redirect_valid = 1'b0;
    req_ready_pct        = 100;
    inst_ready_pct       = 100;
    run_pops("final_drain", 6, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
